// File: rtl/e_out_nibble_collector.sv
// Merges two ap_fifo result streams into one framed nibble stream with a parity probe.
// Optional E_OUT_COLLECTOR_OVF_EN: sticky overflow flag that forces probe_out high.
module e_out_nibble_collector #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [DATA_W-1:0] E_out_0_din,
  input  logic              E_out_0_write,
  output logic              E_out_0_full_n,
  input  logic [DATA_W-1:0] E_out_1_din,
  input  logic              E_out_1_write,
  output logic              E_out_1_full_n,
  output logic [3:0]        data_out,
  output logic              data_valid,
  output logic              probe_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int NN = DATA_W / 4;
  localparam int NW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [NW-1:0] LAST_NIB = NW'(NN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_BODY
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] din [2];
  logic [DATA_W-1:0] head [2];
  logic [DATA_W-1:0] mem_q [2][DEPTH];
  logic [AW-1:0]     wptr_q [2];
  logic [AW-1:0]     wptr_d [2];
  logic [AW-1:0]     rptr_q [2];
  logic [AW-1:0]     rptr_d [2];
  logic [CW-1:0]     cnt_q [2];
  logic [CW-1:0]     cnt_d [2];

  logic [1:0] wr_req;
  logic [1:0] wr_ok;
  logic [1:0] ne;
  logic [1:0] pop;
  logic [1:0] full_n_q, full_n_d;

  logic              any_ne;
  logic              sel;
  logic              pop_go;
  logic [DATA_W-1:0] pop_word;

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [NW-1:0]     nib_q, nib_d;
  logic              ch_q, ch_d;
  logic              last_q, last_d;
  logic              probe_q, probe_d;
  logic [3:0]        dout_q, dout_d;
  logic              dval_q, dval_d;
  logic              is_hdr, is_body;

  assign din[0]    = E_out_0_din;
  assign din[1]    = E_out_1_din;
  assign wr_req[0] = E_out_0_write;
  assign wr_req[1] = E_out_1_write;

  // Channel FIFOs: acceptance depends only on the count at cycle start
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      wr_ok[k]  = wr_req[k] && (cnt_q[k] < DEPTH_C);
      ne[k]     = (cnt_q[k] != '0);
      head[k]   = mem_q[k][rptr_q[k]];
      wptr_d[k] = wr_ok[k] ? wptr_q[k] + AW'(1) : wptr_q[k];
      rptr_d[k] = pop[k] ? rptr_q[k] + AW'(1) : rptr_q[k];
      case ({wr_ok[k], pop[k]})
        2'b10:   cnt_d[k] = cnt_q[k] + CW'(1);
        2'b01:   cnt_d[k] = cnt_q[k] - CW'(1);
        default: cnt_d[k] = cnt_q[k];
      endcase
      full_n_d[k] = (cnt_d[k] < DEPTH_C);
    end
  end

  always_ff @(posedge ap_clk) begin
    for (int k = 0; k < 2; k++) begin
      if (wr_ok[k]) begin
        mem_q[k][wptr_q[k]] <= din[k];
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      for (int k = 0; k < 2; k++) begin
        wptr_q[k] <= '0;
        rptr_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
      full_n_q <= 2'b11;
    end else begin
      for (int k = 0; k < 2; k++) begin
        wptr_q[k] <= wptr_d[k];
        rptr_q[k] <= rptr_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
      full_n_q <= full_n_d;
    end
  end

  assign E_out_0_full_n = full_n_q[0];
  assign E_out_1_full_n = full_n_q[1];

  // Round robin: with both pending, serve the channel not served last
  assign any_ne   = |ne;
  assign sel      = (ne == 2'b11) ? ~last_q : ne[1];
  assign pop[0]   = pop_go & ~sel;
  assign pop[1]   = pop_go & sel;
  assign pop_word = sel ? head[1] : head[0];

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pop_go  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (any_ne) begin
          pop_go  = 1'b1;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        state_d = S_BODY;
      end
      S_BODY: begin
        if (nib_q == LAST_NIB) begin
          if (any_ne) begin
            pop_go  = 1'b1;
            state_d = S_HDR;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign is_hdr  = (state_q == S_HDR);
  assign is_body = (state_q == S_BODY);

  always_comb begin
    dout_d = 4'h0;
    dval_d = 1'b0;
    unique case (1'b1)
      is_hdr: begin
        dout_d = {3'b101, ch_q};
        dval_d = 1'b1;
      end
      is_body: begin
        dout_d = shift_q[3:0];
        dval_d = 1'b1;
      end
      default: begin
        dout_d = 4'h0;
        dval_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    shift_d = shift_q;
    nib_d   = nib_q;
    ch_d    = ch_q;
    last_d  = last_q;
    probe_d = probe_q;
    if (is_hdr) begin
      nib_d = '0;
    end
    if (is_body) begin
      shift_d = shift_q >> 4;
      nib_d   = nib_q + NW'(1);
    end
    // A pop on the last body nibble reloads the shifter after its use
    if (pop_go) begin
      shift_d = pop_word;
      ch_d    = sel;
      last_d  = sel;
      probe_d = probe_q ^ (^pop_word);
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      shift_q <= '0;
      nib_q   <= '0;
      ch_q    <= 1'b0;
      last_q  <= 1'b1;
      probe_q <= 1'b0;
      dout_q  <= 4'h0;
      dval_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      nib_q   <= nib_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
      probe_q <= probe_d;
      dout_q  <= dout_d;
      dval_q  <= dval_d;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = dval_q;

`ifdef E_OUT_COLLECTOR_OVF_EN
  logic ovf_q, ovf_d;

  assign ovf_d = ovf_q | (|(wr_req & ~wr_ok));

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign probe_out = probe_q | ovf_q;
`else
  assign probe_out = probe_q;
`endif

endmodule

// File: tb/tb_e_out_nibble_collector.sv
// Scoreboard bench for e_out_nibble_collector.
// Expected nibbles are queued at write time and checked on every valid output.
module tb_e_out_nibble_collector;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic [31:0] din0, din1;
  logic        wr0, wr1;
  logic        full_n0, full_n1;
  logic [3:0]  data_out;
  logic        data_valid;
  logic        probe_out;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];
  logic       prb_exp;
  int         epoch = 0;
  int         seen_epoch = 0;
  int         run = 0;
  int         max_run = 0;

  e_out_nibble_collector #(
    .DATA_W(32),
    .DEPTH (16)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .E_out_0_din   (din0),
    .E_out_0_write (wr0),
    .E_out_0_full_n(full_n0),
    .E_out_1_din   (din1),
    .E_out_1_write (wr1),
    .E_out_1_full_n(full_n1),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .probe_out     (probe_out)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic ch, input logic [31:0] w);
    exp_q.push_back({3'b101, ch});
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(w[4*i +: 4]);
    end
    prb_exp = prb_exp ^ (^w);
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    wr0 = 1'b0;
    wr1 = 1'b0;
    repeat (2) @(posedge ap_clk);
    #1;
    exp_q.delete();
    prb_exp = 1'b0;
    ap_rst_n = 1'b1;
    epoch++;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge ap_clk);
      n++;
    end
    repeat (3) @(posedge ap_clk);
    #1;
    check("drain_left", exp_q.size(), 0);
  endtask

  always @(negedge ap_clk) begin
    logic [3:0] e;
    if (epoch != seen_epoch) begin
      seen_epoch = epoch;
      run = 0;
      max_run = 0;
    end
    if (data_valid === 1'b1) begin
      run++;
      if (run > max_run) max_run = run;
      if (exp_q.size() == 0) begin
        check("extra_nib", data_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("nib", data_out, e);
      end
    end else begin
      run = 0;
    end
  end

  initial begin
    int sent;
    int guard;
    bit forced;
    bit seen_full;

    din0 = '0;
    din1 = '0;
    prb_exp = 1'b0;
    do_reset();
    check("rst_dval", data_valid, 0);
    check("rst_dout", data_out, 0);
    check("rst_probe", probe_out, 0);
    check("rst_full0", full_n0, 1);
    check("rst_full1", full_n1, 1);

    // single word, latency and sequence
    din0 = 32'h12345678;
    wr0 = 1'b1;
    push_word(1'b0, din0);
    @(posedge ap_clk);
    #1;
    wr0 = 1'b0;
    @(negedge ap_clk);
    @(negedge ap_clk);
    check("lat_t1", data_valid, 0);
    @(negedge ap_clk);
    check("lat_t2", data_valid, 1);
    drain(60);
    check("run_single", max_run, 9);
    check("probe_single", probe_out, 1);

    // simultaneous writes on both channels
    do_reset();
    din0 = 32'h00000001;
    din1 = 32'h00000003;
    wr0 = 1'b1;
    wr1 = 1'b1;
    push_word(1'b0, din0);
    push_word(1'b1, din1);
    @(posedge ap_clk);
    #1;
    wr0 = 1'b0;
    wr1 = 1'b0;
    drain(80);
    check("run_dual", max_run, 18);
    check("probe_dual", probe_out, 1);

    // alternation with both channels kept busy
    do_reset();
    for (int i = 0; i < 4; i++) begin
      din0 = 32'hA0C0_0000 | i;
      din1 = 32'h5B10_0700 | (i << 4);
      wr0 = 1'b1;
      wr1 = 1'b1;
      push_word(1'b0, din0);
      push_word(1'b1, din1);
      @(posedge ap_clk);
      #1;
    end
    wr0 = 1'b0;
    wr1 = 1'b0;
    drain(200);
    check("run_alt", max_run, 72);
    check("probe_alt", probe_out, prb_exp);

    // burst on ch0 obeying full_n, plus one forced write while full
    do_reset();
    sent = 0;
    guard = 0;
    forced = 0;
    seen_full = 0;
    while (sent < 20 && guard < 3000) begin
      wr0 = 1'b0;
      if (full_n0) begin
        din0 = 32'h0100_0000 + sent * 32'h0001_0203;
        wr0 = 1'b1;
        push_word(1'b0, din0);
        sent++;
      end else begin
        seen_full = 1;
        if (!forced) begin
          din0 = 32'hDEAD_BEEF;
          wr0 = 1'b1;
          forced = 1;
        end
      end
      @(posedge ap_clk);
      #1;
      guard++;
    end
    wr0 = 1'b0;
    check("burst_sent", sent, 20);
    check("burst_full_seen", seen_full, 1);
    drain(600);
    check("burst_full_back", full_n0, 1);
`ifdef E_OUT_COLLECTOR_OVF_EN
    check("probe_ovf", probe_out, 1);
`else
    check("probe_burst", probe_out, prb_exp);
`endif

    // reset in the middle of a frame with words still queued
    do_reset();
    for (int i = 0; i < 3; i++) begin
      din0 = 32'h1111_1111 * (i + 1);
      wr0 = 1'b1;
      push_word(1'b0, din0);
      @(posedge ap_clk);
      #1;
    end
    wr0 = 1'b0;
    guard = 0;
    while (exp_q.size() > 22 && guard < 100) begin
      @(posedge ap_clk);
      #1;
      guard++;
    end
    check("mid_reached", exp_q.size() <= 22, 1);
    ap_rst_n = 1'b0;
    @(posedge ap_clk);
    #1;
    exp_q.delete();
    prb_exp = 1'b0;
    check("mid_dval", data_valid, 0);
    check("mid_probe", probe_out, 0);
    check("mid_full0", full_n0, 1);
    check("mid_full1", full_n1, 1);
    ap_rst_n = 1'b1;
    epoch++;
    repeat (30) @(posedge ap_clk);
    #1;
    check("mid_empty", max_run, 0);
    check("mid_probe_hold", probe_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
